// File: rtl/signal_pkg.sv
// Shared definitions for the serial link: transmitter FSM encoding, default
// frame geometry and the frame-width-derived counter sizing. The receive-side
// shift register imports the same package so both ends agree on widths.
package signal_pkg;

  // Transmitter FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } ser_state_t;

  // Default frame geometry: SAMPLES samples of OSF bits each.
  localparam int SAMPLES_DEFAULT = 128;
  localparam int OSF_DEFAULT     = 8;

  // Width of the bit-rate divider counter; DIV may be anything in 1..65535.
  localparam int DIV_CNT_W = 16;

  // Bits needed to count 0..frame_w inclusive, so the counter never wraps.
  function automatic int bit_cnt_width(input int frame_w);
    return $clog2(frame_w + 1);
  endfunction

endpackage

// File: rtl/shift_tick_gen.sv
// Bit-rate strobe generator. A restart aligns the phase so that the first tick
// lands DIV-1 cycles after the first serial bit; while enabled it then ticks
// once every DIV cycles. The tick is registered, so the serializer sees it in
// the cycle before the edge that launches the next bit.
module shift_tick_gen
  import signal_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic enable,
  input  logic restart,
  output logic tick
);

  localparam logic [DIV_CNT_W-1:0] DIV_LAST = DIV_CNT_W'(DIV - 1);
  localparam logic [DIV_CNT_W-1:0] CNT_ONE  = DIV_CNT_W'(1);

  logic [DIV_CNT_W-1:0] div_cnt_reg, div_cnt_next;
  logic                 tick_reg, tick_next;

  // Advance the divider modulo DIV; restart wins and realigns the phase.
  always_comb begin
    div_cnt_next = '0;
    tick_next    = 1'b0;
    if (restart) begin
      div_cnt_next = '0;
    end else if (enable) begin
      div_cnt_next = (div_cnt_reg == DIV_LAST) ? '0 : (div_cnt_reg + CNT_ONE);
    end
    if (restart || enable) begin
      tick_next = (div_cnt_next == DIV_LAST);
    end
  end

  // Divider state and registered tick.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      div_cnt_reg <= '0;
      tick_reg    <= 1'b0;
    end else begin
      div_cnt_reg <= div_cnt_next;
      tick_reg    <= tick_next;
    end
  end

  assign tick = tick_reg;

endmodule

// File: rtl/signal_serializer.sv
// Parallel-to-serial frame transmitter. A frame of SAMPLES*OSF bits is
// captured on acceptance and sent LSB first, one bit per DIV clock cycles,
// with a Shift strobe per bit that can drive a receiver's shift enable.
// Every output comes straight from a flip-flop.
module signal_serializer
  import signal_pkg::*;
#(
  parameter int SAMPLES = SAMPLES_DEFAULT,
  parameter int OSF     = OSF_DEFAULT,
  parameter int DIV     = 1
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic                   Load,
  input  logic [SAMPLES*OSF-1:0] Data_In,
  input  logic                   Abort,
  output logic                   Ready,
  output logic                   Data_Out,
  output logic                   Shift,
  output logic                   Busy,
  output logic                   Done
);

  localparam int W         = SAMPLES * OSF;
  localparam int BIT_CNT_W = bit_cnt_width(W);
  localparam logic [BIT_CNT_W-1:0] LAST_CNT = BIT_CNT_W'(W);
  localparam logic [BIT_CNT_W-1:0] CNT_ONE  = BIT_CNT_W'(1);

  ser_state_t           state_reg, state_next;
  logic [W-1:0]         shadow_reg, shadow_next;
  logic [BIT_CNT_W-1:0] bit_cnt_reg, bit_cnt_next;
  logic                 ready_reg, ready_next;
  logic                 data_out_reg, data_out_next;
  logic                 shift_reg, shift_next;
  logic                 busy_reg, busy_next;
  logic                 done_reg, done_next;

  // The shadow register holds only the bits not yet sent: bit 0 goes out on
  // the acceptance edge, so the capture stores Data_In already shifted once.
  logic [W-1:0] load_shr;
  logic [W-1:0] shadow_shr;
  logic         accept;
  logic         tick_enable;
  logic         tick;

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_shr
      if (gi == W - 1) begin : g_top
        assign load_shr[gi]   = 1'b0;
        assign shadow_shr[gi] = 1'b0;
      end else begin : g_low
        assign load_shr[gi]   = Data_In[gi+1];
        assign shadow_shr[gi] = shadow_reg[gi+1];
      end
    end
  endgenerate

  // Ready is registered, so acceptance only depends on Load and a flop.
  assign accept      = Load && ready_reg;
  assign tick_enable = (state_reg == ST_SHIFT);

  shift_tick_gen #(
    .DIV(DIV)
  ) u_tick_gen (
    .Clk    (Clk),
    .Reset_n(Reset_n),
    .enable (tick_enable),
    .restart(accept),
    .tick   (tick)
  );

  // Next-state and next-output logic; outputs are computed one cycle early
  // so they can be registered.
  always_comb begin
    state_next    = state_reg;
    shadow_next   = shadow_reg;
    bit_cnt_next  = bit_cnt_reg;
    data_out_next = data_out_reg;
    shift_next    = 1'b0;
    busy_next     = 1'b0;
    done_next     = 1'b0;
    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          state_next    = ST_SHIFT;
          shadow_next   = load_shr;
          bit_cnt_next  = CNT_ONE;
          data_out_next = Data_In[0];
          shift_next    = 1'b1;
          busy_next     = 1'b1;
        end else begin
          state_next   = ST_IDLE;
          bit_cnt_next = '0;
        end
      end
      ST_SHIFT: begin
        if (Abort) begin
          // Cancel: drop the rest of the frame, keep the line level.
          state_next   = ST_IDLE;
          bit_cnt_next = '0;
        end else if (bit_cnt_reg == LAST_CNT) begin
          // The current cycle carries the last strobe; report completion.
          state_next   = ST_DONE;
          bit_cnt_next = '0;
          done_next    = 1'b1;
        end else begin
          busy_next = 1'b1;
          if (tick) begin
            data_out_next = shadow_reg[0];
            shadow_next   = shadow_shr;
            bit_cnt_next  = bit_cnt_reg + CNT_ONE;
            shift_next    = 1'b1;
          end
        end
      end
      default: begin
        state_next   = ST_IDLE;
        bit_cnt_next = '0;
      end
    endcase
    ready_next = (state_next != ST_SHIFT);
  end

  // State, shadow register, counters and registered outputs.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg    <= ST_IDLE;
      shadow_reg   <= '0;
      bit_cnt_reg  <= '0;
      ready_reg    <= 1'b1;
      data_out_reg <= 1'b0;
      shift_reg    <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      shadow_reg   <= shadow_next;
      bit_cnt_reg  <= bit_cnt_next;
      ready_reg    <= ready_next;
      data_out_reg <= data_out_next;
      shift_reg    <= shift_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
    end
  end

  assign Ready    = ready_reg;
  assign Data_Out = data_out_reg;
  assign Shift    = shift_reg;
  assign Busy     = busy_reg;
  assign Done     = done_reg;

endmodule

// File: tb/tb_signal_serializer.sv
// Directed bench for signal_serializer with W=8: one instance at DIV=1 and one
// at DIV=3. Expected serial bits are queued when a frame is loaded and popped
// on every Shift strobe; a behavioural SIPO receiver is looped back from the
// DIV=1 instance.
module tb_signal_serializer;

  localparam int SAMPLES = 4;
  localparam int OSF     = 2;
  localparam int W       = SAMPLES * OSF;

  logic clk = 1'b0;
  logic rst_n;

  logic         load1, abort1, ready1, data_out1, shift1, busy1, done1;
  logic [W-1:0] din1;
  logic         load3, abort3, ready3, data_out3, shift3, busy3, done3;
  logic [W-1:0] din3;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic q1[$];
  logic q3[$];

  int         strobes1, busy_cnt1, done_cnt1, s1_first, s1_last, done_cyc1;
  logic       last1;
  logic [7:0] rx1;
  int         strobes3, busy_cnt3, done_cnt3, s3_first, s3_last, done_cyc3;
  logic       last3;
  int         prev_done;

  always #5 clk = ~clk;

  signal_serializer #(.SAMPLES(SAMPLES), .OSF(OSF), .DIV(1)) u_dut1 (
    .Clk(clk), .Reset_n(rst_n), .Load(load1), .Data_In(din1), .Abort(abort1),
    .Ready(ready1), .Data_Out(data_out1), .Shift(shift1), .Busy(busy1), .Done(done1)
  );

  signal_serializer #(.SAMPLES(SAMPLES), .OSF(OSF), .DIV(3)) u_dut3 (
    .Clk(clk), .Reset_n(rst_n), .Load(load3), .Data_In(din3), .Abort(abort3),
    .Ready(ready3), .Data_Out(data_out3), .Shift(shift3), .Busy(busy3), .Done(done3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push1(input logic [7:0] v);
    for (int i = 0; i < 8; i++) q1.push_back(v[i]);
  endtask

  task automatic push3(input logic [7:0] v);
    for (int i = 0; i < 8; i++) q3.push_back(v[i]);
  endtask

  task automatic clr1();
    strobes1 = 0; busy_cnt1 = 0; done_cnt1 = 0;
    s1_first = -1; s1_last = -1; done_cyc1 = -1;
  endtask

  task automatic clr3();
    strobes3 = 0; busy_cnt3 = 0; done_cnt3 = 0;
    s3_first = -1; s3_last = -1; done_cyc3 = -1;
  endtask

  // One clock cycle: sample both instances after the edge, score strobes.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (shift1 === 1'b1) begin
      if (q1.size() > 0) chk("d1_bit", data_out1, q1.pop_front());
      else chk("d1_unexpected_strobe", shift1, 0);
      if (s1_first < 0) s1_first = cyc;
      s1_last = cyc;
      strobes1++;
      rx1   = {data_out1, rx1[7:1]};
      last1 = data_out1;
    end else begin
      chk("d1_hold", data_out1, last1);
    end
    if (busy1 === 1'b1) busy_cnt1++;
    if (done1 === 1'b1) begin done_cnt1++; done_cyc1 = cyc; end

    if (shift3 === 1'b1) begin
      if (q3.size() > 0) chk("d3_bit", data_out3, q3.pop_front());
      else chk("d3_unexpected_strobe", shift3, 0);
      if (s3_last >= 0) chk("d3_gap", cyc - s3_last, 3);
      if (s3_first < 0) s3_first = cyc;
      s3_last = cyc;
      strobes3++;
      last3 = data_out3;
    end else begin
      chk("d3_hold", data_out3, last3);
    end
    if (busy3 === 1'b1) busy_cnt3++;
    if (done3 === 1'b1) begin done_cnt3++; done_cyc3 = cyc; end
  endtask

  initial begin
    rst_n = 1'b0;
    load1 = 1'b0; abort1 = 1'b0; din1 = '0;
    load3 = 1'b0; abort3 = 1'b0; din3 = '0;
    last1 = 1'b0; last3 = 1'b0; rx1 = '0;
    clr1(); clr3();

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready1", ready1, 1);
    chk("rst_data_out1", data_out1, 0);
    chk("rst_shift1", shift1, 0);
    chk("rst_busy1", busy1, 0);
    chk("rst_done1", done1, 0);
    chk("rst_ready3", ready3, 1);
    chk("rst_shift3", shift3, 0);

    // DIV=1, 8'hA5, load on the first edge after release
    rst_n = 1'b1; load1 = 1'b1; din1 = 8'hA5; push1(8'hA5);
    step(); load1 = 1'b0;
    chk("a5_first_strobe", shift1, 1);
    repeat (8) step();
    chk("a5_done", done1, 1);
    chk("a5_ready_in_done", ready1, 1);
    chk("a5_shift_in_done", shift1, 0);
    step();
    chk("a5_done_once", done1, 0);
    chk("a5_strobes", strobes1, 8);
    chk("a5_consecutive", s1_last - s1_first, 7);
    chk("a5_busy_cycles", busy_cnt1, 8);
    chk("a5_done_count", done_cnt1, 1);
    chk("a5_done_after_last", done_cyc1 - s1_last, 1);

    // DIV=3, 8'h01
    load3 = 1'b1; din3 = 8'h01; push3(8'h01);
    step(); load3 = 1'b0;
    chk("div3_first_strobe", shift3, 1);
    repeat (26) step();
    chk("div3_strobes", strobes3, 8);
    chk("div3_busy_cycles", busy_cnt3, 22);
    chk("div3_span", s3_last - s3_first, 21);
    chk("div3_done_count", done_cnt3, 1);
    chk("div3_done_after_last", done_cyc3 - s3_last, 1);
    chk("div3_queue_empty", q3.size(), 0);

    // Loopback, back-to-back frames 8'h3C then 8'hC3 loaded in DONE
    clr1(); rx1 = '0;
    load1 = 1'b1; din1 = 8'h3C; push1(8'h3C);
    step(); load1 = 1'b0;
    repeat (8) step();
    chk("lb_done_first", done1, 1);
    chk("lb_rx_first", rx1, 8'h3C);
    prev_done = done_cyc1;
    clr1();
    load1 = 1'b1; din1 = 8'hC3; push1(8'hC3);
    step(); load1 = 1'b0;
    chk("lb_b2b_gap", s1_first - prev_done, 1);
    repeat (8) step();
    chk("lb_done_second", done1, 1);
    chk("lb_rx_second", rx1, 8'hC3);
    chk("lb_strobes_second", strobes1, 8);
    step();

    // Abort after the 3rd strobe of 8'hFF
    clr1();
    load1 = 1'b1; din1 = 8'hFF; push1(8'hFF);
    step(); load1 = 1'b0;
    step(); step();
    chk("ab_three_sent", strobes1, 3);
    abort1 = 1'b1; q1.delete();
    step(); abort1 = 1'b0;
    chk("ab_shift", shift1, 0);
    chk("ab_busy", busy1, 0);
    chk("ab_ready", ready1, 1);
    chk("ab_line_held", data_out1, 1);
    repeat (12) step();
    chk("ab_strobes", strobes1, 3);
    chk("ab_no_done", done_cnt1, 0);

    // Abort together with Load while idle: Load wins
    clr1();
    abort1 = 1'b1; load1 = 1'b1; din1 = 8'h5A; push1(8'h5A);
    step(); abort1 = 1'b0; load1 = 1'b0;
    chk("idle_abort_load", shift1, 1);
    repeat (9) step();
    chk("idle_abort_strobes", strobes1, 8);
    chk("idle_abort_done", done_cnt1, 1);

    // Reset after the 5th strobe, then 8'h81
    clr1();
    load1 = 1'b1; din1 = 8'h7E; push1(8'h7E);
    step(); load1 = 1'b0;
    repeat (4) step();
    chk("rs_five_sent", strobes1, 5);
    rst_n = 1'b0;
    #1;
    q1.delete(); last1 = 1'b0; last3 = 1'b0;
    chk("rs_ready", ready1, 1);
    chk("rs_shift", shift1, 0);
    chk("rs_busy", busy1, 0);
    chk("rs_done", done1, 0);
    chk("rs_data_out", data_out1, 0);
    repeat (3) step();
    chk("rs_no_strobes_in_reset", strobes1, 5);
    chk("rs_ready_held", ready1, 1);
    clr1();
    rst_n = 1'b1; load1 = 1'b1; din1 = 8'h81; push1(8'h81);
    step(); load1 = 1'b0;
    chk("rs_first_accept", shift1, 1);
    repeat (8) step();
    chk("rs_strobes", strobes1, 8);
    chk("rs_done_count", done_cnt1, 1);
    chk("rs_queue_empty", q1.size(), 0);
    step();

    // Load of 8'h00 during SHIFT is ignored
    clr1(); rx1 = '0;
    load1 = 1'b1; din1 = 8'hB6; push1(8'hB6);
    step(); load1 = 1'b0;
    step(); step();
    load1 = 1'b1; din1 = 8'h00;
    step(); load1 = 1'b0;
    repeat (14) step();
    chk("ign_strobes", strobes1, 8);
    chk("ign_done_count", done_cnt1, 1);
    chk("ign_rx", rx1, 8'hB6);
    chk("ign_queue_empty", q1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
